// File: rtl/muldiv_hilo.sv
// muldiv_hilo: iterative multiply/divide unit that owns the architectural
// HI/LO registers. Supports MULT, MULTU, DIV, DIVU, MTHI and MTLO.
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous active-high reset, clears all state
//   start          request strobe, only accepted while the unit is idle
//   op[2:0]        000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                  100 MTHI, 101 MTLO, 11x ignored
//   rs_data        multiplicand / dividend / move source
//   rt_data        multiplier / divisor
//   hi, lo         architectural HI/LO registers
//   busy           high while a multiply/divide is in flight
//   done           one-cycle pulse after HI/LO are written by MULT/DIV
//
// Optional build macro: MULDIV_FAST_MULT_EN. When it is defined, MULT and
// MULTU use a single-cycle multiplier at the start edge and go straight
// to FIX. Divides always use the iterative path.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO are applied here
// RUN   | one shift-add / restoring shift-subtract step per cycle
// FIX   | sign correction, write HI/LO, pulse done
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;     // mult: {partial, multiplier}; div: {rem, quot}
  logic [WIDTH-1:0]     dvsr;    // multiplicand or divisor magnitude
  logic                 is_div;
  logic                 neg_q;   // negate product / quotient
  logic                 neg_r;   // negate remainder

  logic                 accept;
  logic                 req_mul;
  logic                 req_div;
  logic                 use_sign;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     a_abs;
  logic [WIDTH-1:0]     b_abs;

  assign accept  = start && (state == IDLE);
  assign req_mul = accept && (op[2:1] == 2'b00);
  assign req_div = accept && (op[2:1] == 2'b01);

  // A divide by zero is run unsigned: the restoring loop then leaves the
  // raw dividend in the remainder and all ones in the quotient.
  assign use_sign = !op[0] && !(op[1] && (rt_data == '0));
  assign a_neg    = use_sign && rs_data[WIDTH-1];
  assign b_neg    = use_sign && rt_data[WIDTH-1];
  assign a_abs    = a_neg ? -rs_data : rs_data;
  assign b_abs    = b_neg ? -rt_data : rt_data;

`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, a_abs} * {{WIDTH{1'b0}}, b_abs};
`endif

  // One iteration of either algorithm.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_tmp;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] step_nxt;

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dvsr} : '0);
    div_tmp  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge   = (div_tmp >= {1'b0, dvsr});
    // When the trial fails the top bit of div_tmp is necessarily zero,
    // and a successful difference always fits in WIDTH bits.
    div_rem  = div_ge ? (div_tmp[WIDTH-1:0] - dvsr) : div_tmp[WIDTH-1:0];
    step_nxt = is_div ? {div_rem, acc[WIDTH-2:0], div_ge}
                      : {mul_sum, acc[WIDTH-1:1]};
  end

  // Sign correction applied in FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   hi_res;
  logic [WIDTH-1:0]   lo_res;

  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    if (is_div) begin
      hi_res = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      lo_res = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end else begin
      hi_res = prod_fix[2*WIDTH-1:WIDTH];
      lo_res = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_div) begin
          state_nxt = RUN;
        end else if (req_mul) begin
`ifdef MULDIV_FAST_MULT_EN
          state_nxt = FIX;
`else
          state_nxt = RUN;
`endif
        end
      end
      RUN:     if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      dvsr   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      done <= (state == FIX);
      case (state)
        IDLE: begin
          if (accept) begin
            if (op == 3'b100) begin
              hi <= rs_data;
            end else if (op == 3'b101) begin
              lo <= rs_data;
            end else if (!op[2]) begin
              is_div <= op[1];
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
              cnt    <= '0;
              dvsr   <= op[1] ? b_abs : a_abs;
              acc    <= {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
`ifdef MULDIV_FAST_MULT_EN
              if (!op[1]) acc <= fast_prod;
`endif
            end
          end
        end
        RUN: begin
          acc <= step_nxt;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          hi <= hi_res;
          lo <= lo_res;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
module tb_muldiv_hilo;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  muldiv_hilo #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one op just before the next rising edge, scrambles the operand
  // inputs afterwards, counts edges until busy drops and checks the latency
  // and the done pulse. inj > 0 presents an MTHI request inj edges in.
  task automatic run_op(input string tag, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input int inj);
    int cyc;
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; rs_data = $urandom; rt_data = $urandom;
    cyc = 0;
    while (busy && cyc < 100) begin
      if (inj > 0 && cyc == inj) begin
        start = 1'b1; op = 3'b100; rs_data = 32'h1234_5678;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic done_low(input string tag);
    @(posedge clock); #1;
    chk({tag, "_done_low"}, 64'(done), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'b000; rs_data = '0; rt_data = '0;
    #1;
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 0);
    chk("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_max_lo", 64'(lo), 64'h0000_0001);
    done_low("multu_max");

    run_op("mult_neg", 3'b000, 32'hFFFF_FFFD, 32'h0000_0007, MUL_LAT, 0);
    chk("mult_neg_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_neg_lo", 64'(lo), 64'hFFFF_FFEB);
    done_low("mult_neg");

    run_op("mult_minmin", 3'b000, 32'h8000_0000, 32'h8000_0000, MUL_LAT, 0);
    chk("mult_minmin_hi", 64'(hi), 64'h4000_0000);
    chk("mult_minmin_lo", 64'(lo), 64'h0000_0000);
    done_low("mult_minmin");

    run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'h0000_0002, DIV_LAT, 0);
    chk("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);
    done_low("div_neg");

    run_op("div_negdiv", 3'b010, 32'h0000_0007, 32'hFFFF_FFFE, DIV_LAT, 0);
    chk("div_negdiv_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_negdiv_hi", 64'(hi), 64'h0000_0001);
    done_low("div_negdiv");

    run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, 0);
    chk("div_ovf_lo", 64'(lo), 64'h8000_0000);
    chk("div_ovf_hi", 64'(hi), 64'h0000_0000);
    done_low("div_ovf");

    run_op("divu_zero", 3'b011, 32'h0000_0007, 32'h0000_0000, DIV_LAT, 0);
    chk("divu_zero_hi", 64'(hi), 64'h0000_0007);
    chk("divu_zero_lo", 64'(lo), 64'hFFFF_FFFF);
    done_low("divu_zero");

    run_op("div_zero", 3'b010, 32'hFFFF_FFF9, 32'h0000_0000, DIV_LAT, 0);
    chk("div_zero_hi", 64'(hi), 64'hFFFF_FFF9);
    chk("div_zero_lo", 64'(lo), 64'hFFFF_FFFF);
    done_low("div_zero");

    // MTHI presented while busy must be dropped.
    run_op("divu_rej", 3'b011, 32'd100, 32'd7, DIV_LAT, 5);
    chk("divu_rej_hi", 64'(hi), 64'd2);
    chk("divu_rej_lo", 64'(lo), 64'd14);
    done_low("divu_rej");

    op = 3'b100; rs_data = 32'h1234_5678; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("mthi_hi", 64'(hi), 64'h1234_5678);
    chk("mthi_busy", 64'(busy), 64'd0);
    chk("mthi_done", 64'(done), 64'd0);

    op = 3'b101; rs_data = 32'hCAFE_BABE; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'hCAFE_BABE);
    chk("mtlo_hi", 64'(hi), 64'h1234_5678);

    op = 3'b110; rs_data = 32'hDEAD_BEEF; rt_data = 32'h1; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("op110_busy", 64'(busy), 64'd0);
    chk("op110_hilo", {hi, lo}, 64'h1234_5678_CAFE_BABE);
    @(posedge clock); #1;
    chk("op110_done", 64'(done), 64'd0);

    // Reset asynchronously in the middle of a divide.
    op = 3'b011; rs_data = 32'd1000; rt_data = 32'd3; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("rst_mid_hi", 64'(hi), 64'd0);
    chk("rst_mid_lo", 64'(lo), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    chk("rst_hold_busy", 64'(busy), 64'd0);

    run_op("multu_small", 3'b001, 32'd3, 32'd5, MUL_LAT, 0);
    chk("multu_small_lo", 64'(lo), 64'd15);
    chk("multu_small_hi", 64'(hi), 64'd0);
    // Next request issued in the done cycle.
    run_op("divu_b2b", 3'b011, 32'd15, 32'd4, DIV_LAT, 0);
    chk("divu_b2b_lo", 64'(lo), 64'd3);
    chk("divu_b2b_hi", 64'(hi), 64'd3);
    done_low("divu_b2b");

    run_op("multu_fast", 3'b001, 32'h0001_0000, 32'h0001_0000, MUL_LAT, 0);
    chk("multu_fast_hi", 64'(hi), 64'h0000_0001);
    chk("multu_fast_lo", 64'(lo), 64'h0000_0000);
    done_low("multu_fast");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
